// File: rtl/mutex_arb_if.sv
// mutex_arb_if: request/grant bundle between requesters and the mutex arbiter.
// master = requester side, slave = arbiter side.
interface mutex_arb_if #(
    parameter int N_REQ = 4
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             busy;
    logic             revoke;

    modport master (
        output req,
        input  gnt, gnt_id, busy, revoke
    );

    modport slave (
        input  req,
        output gnt, gnt_id, busy, revoke
    );
endinterface

// File: rtl/mutex_arb.sv
// mutex_arb: N-requester mutual-exclusion arbiter, fixed or round-robin.
// Optional hold timeout with forced revoke when MUTEX_TIMEOUT_EN is defined.
module mutex_arb #(
    parameter int N_REQ          = 4,
    parameter int RR_EN          = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic      clk,
    input  logic      arst_n,
    mutex_arb_if.slave bus
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t           state, state_n;
    logic [N_REQ-1:0] gnt_q, gnt_n;
    logic [N_REQ-1:0] elig, mask;
    logic [ID_W-1:0]  id_q, id_n;
    logic [ID_W-1:0]  ptr_q, ptr_n, ptr_adv;
    logic [ID_W-1:0]  start, win_id;
    logic             win_found;
    logic             rev_q, rev_n;
    logic             owner_req, expire;

    assign owner_req = bus.req[id_q];
    assign elig      = bus.req & ~mask;
    assign start     = (RR_EN != 0) ? ptr_q : '0;
    assign ptr_adv   = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;

`ifdef MUTEX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [N_REQ-1:0] mask_q, mask_n;

    assign mask   = mask_q;
    assign expire = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Hold counter and revoke mask: mask bit stays set until that port drops req
    always_comb begin
        cnt_n  = cnt_q;
        mask_n = mask_q & bus.req;
        if (state == IDLE && win_found) begin
            cnt_n = '0;
        end else if (state == OWNED && owner_req) begin
            if (expire) begin
                mask_n[id_q] = 1'b1;
            end else begin
                cnt_n = cnt_q + 1'b1;
            end
        end
    end

    // Timeout state registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q  <= '0;
            mask_q <= '0;
        end else begin
            cnt_q  <= cnt_n;
            mask_q <= mask_n;
        end
    end
`else
    logic unused_timeout;

    assign mask           = '0;
    assign expire         = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Winner search: first eligible port scanning upward from start, wrapping
    always_comb begin : p_win
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(start) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!win_found && elig[ID_W'(idx)]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    // Next-state: grant from IDLE, release or revoke from OWNED
    always_comb begin
        state_n = state;
        gnt_n   = gnt_q;
        id_n    = id_q;
        ptr_n   = ptr_q;
        rev_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (win_found) begin
                    state_n = OWNED;
                    gnt_n   = N_REQ'(1) << win_id;
                    id_n    = win_id;
                end
            end
            OWNED: begin
                if (!owner_req || expire) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    ptr_n   = ptr_adv;
                    rev_n   = owner_req;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Arbiter state registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
            gnt_q <= '0;
            id_q  <= '0;
            ptr_q <= '0;
            rev_q <= 1'b0;
        end else begin
            state <= state_n;
            gnt_q <= gnt_n;
            id_q  <= id_n;
            ptr_q <= ptr_n;
            rev_q <= rev_n;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.gnt_id = id_q;
    assign bus.busy   = (state == OWNED);
    assign bus.revoke = rev_q;
endmodule
